gadget_pool: RTL and testbench
==============================

GADGET_POOL -- requirements
Module: gadget_pool

Interface
REQ-001 SHALL have parameters, each with name, default and meaning:
- NUM_SLOTS, 4: concurrent gadgets, 1..8.
- XW, 10: X width.
- YW, 10: Y width.
- TYPE_W, 3: type width; type 0 = none.
- STEP_W, 5: speedstep width.
- INIT_STEP, 5: first-frame speed.
- MAX_STEP, 15: fall speed cap.
- FLOOR_Y, 479: bottom boundary.
REQ-002 SHALL have ports, each with name, direction, width and meaning:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_cal_frame, in, 1: frame-start pulse.
- i_gadget_gen, in, 1: brick broken, spawn request.
- i_gadget_type_by_brick, in, TYPE_W: spawn type.
- i_gadget_initX, in, XW: spawn X.
- i_gadget_initY, in, YW: spawn Y.
- i_gadget_eaten, in, 1: paddle caught a gadget.
- i_eaten_slot, in, clog2(NUM_SLOTS): slot that was caught.
- i_gadget_req, in, 1: consumer ready for a move.
- o_gadget_ack, out, 1: move offered.
- o_move_slot, out, clog2(NUM_SLOTS): slot being moved.
- o_gadget_frame_term, out, 1: frame-done pulse.
- o_slot_active, out, NUM_SLOTS: occupancy bitmap.
- o_gadgetX, out, NUM_SLOTS*XW: packed positions, slot 0 in LSBs.
- o_gadgetY, out, NUM_SLOTS*YW: packed positions, slot 0 in LSBs.
- o_gadget_type, out, NUM_SLOTS*TYPE_W: packed types, slot 0 in LSBs.
- o_gen_drop, out, 1: spawn lost, pool full.

Function
REQ-003 Slot state SHALL be: active, X, Y, type, speedstep (STEP_W), direc_y (0 = up/-Y, 1 = down/+Y).
REQ-004 A spawn SHALL occur when i_gadget_gen=1 and type!=0:
- Lowest-index free slot loads init X/Y and type, speedstep=INIT_STEP, direc_y=0, active=1, on the next edge.
- Type 0 SHALL be ignored.
REQ-005 On a spawn with no free slot: no state change; o_gen_drop pulses 1 cycle.
REQ-006 On i_gadget_eaten: slot i_eaten_slot SHALL clear (active=0, type=0) next edge; eating an inactive slot is a no-op.
REQ-007 Eat and spawn in the same cycle: eat SHALL win for its slot; allocation uses the pre-eat free mask.
REQ-008 FSM states SHALL be IDLE, SELECT, MOVE, FRAME_TERM.
- IDLE -> SELECT on i_cal_frame.
- SELECT scans for the next active slot index at or above the current pointer: found -> MOVE with counter=speedstep; none -> FRAME_TERM.
- FRAME_TERM: o_gadget_frame_term=1 for exactly 1 cycle -> IDLE.
- i_cal_frame outside IDLE SHALL be ignored.
REQ-009 In MOVE, o_gadget_ack=1 and o_move_slot=pointer.
- Handshake = i_gadget_req && o_gadget_ack.
- Each handshake moves Y by 1 pixel (up: -1, down: +1) and decrements counter.
- The consumer may stall i_gadget_req indefinitely.
REQ-010 When a handshake leaves counter=0, the slot's speed SHALL update, then pointer+1 -> SELECT:
- up, step!=1: step-2.
- up, step==1: direc_y=1, step unchanged.
- down, step<MAX_STEP: step+2, saturating at MAX_STEP.
REQ-011 Up-move handshake reaching Y=0 SHALL set direc_y=1 and continue the remaining counts downward.
REQ-012 Down-move handshake reaching Y>=FLOOR_Y SHALL clear the slot (missed); remaining counts are skipped; -> SELECT.
REQ-013 Moved slot eaten during MOVE: o_gadget_ack SHALL drop next cycle; pending handshake discarded; -> SELECT.
REQ-014 A slot spawned during a frame's scan SHALL move only if its index is above the pointer.
REQ-015 X SHALL never change after spawn; arithmetic on Y is YW-bit unsigned without wrap (REQ-011/012 guard both ends).

Reset
REQ-016 While rst_n=0, asynchronously:
- All slots inactive; X, Y, type, speedstep, direc_y = 0.
- FSM=IDLE; pointer=0; counter=0.
- All outputs 0.
REQ-017 Reset mid-frame SHALL abort the frame with no o_gadget_frame_term; the first i_cal_frame after release starts a fresh frame.

Configuration
REQ-018 With macro GADGET_POOL_MISS_CNT_EN defined:
- Adds output o_miss_cnt, 8 bits, incrementing on each REQ-012 clear and saturating at 255; reset 0.
- Undefined: port and logic absent, behaviour otherwise identical.

Verification
REQ-019 Spawn (100,200), type 2, req held 1, frames 1-4 -> frame 1: 5 acks, Y=195, step 3; frame 2: Y=192, step 1; frame 3: Y=191, direc_y=1, step 1; frame 4: Y=192, step 3.
REQ-020 Five spawns with NUM_SLOTS=4 -> slots 0-3 filled, fifth gives o_gen_drop=1 for 1 cycle, o_slot_active=4'b1111.
REQ-021 Slot down at Y=477, step 5, req=1 -> 2 handshakes, slot cleared at Y=479, o_slot_active bit 0, miss_cnt=1 when enabled.
REQ-022 Eat slot 1 while it is in MOVE with req=0 -> ack deasserts next cycle, slot 1 inactive, frame proceeds to slot 2, frame_term pulses once.
REQ-023 rst_n low mid-MOVE -> all outputs 0 immediately; no frame_term; next i_cal_frame with no active slots -> frame_term 2 cycles later.

Source files
------------

// File: rtl/gadget_pool.sv
// Falling-gadget pool: spawns gadgets from broken bricks and steps their Y once per handshake, frame by frame.
// Optional GADGET_POOL_MISS_CNT_EN adds an 8-bit saturating count of gadgets lost at the floor.
module gadget_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int TYPE_W    = 3,
    parameter int STEP_W    = 5,
    parameter int INIT_STEP = 5,
    parameter int MAX_STEP  = 15,
    parameter int FLOOR_Y   = 479,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cal_frame,
    input  logic                          i_gadget_gen,
    input  logic [TYPE_W-1:0]             i_gadget_type_by_brick,
    input  logic [XW-1:0]                 i_gadget_initX,
    input  logic [YW-1:0]                 i_gadget_initY,
    input  logic                          i_gadget_eaten,
    input  logic [SW-1:0]                 i_eaten_slot,
    input  logic                          i_gadget_req,
    output logic                          o_gadget_ack,
    output logic [SW-1:0]                 o_move_slot,
    output logic                          o_gadget_frame_term,
    output logic [NUM_SLOTS-1:0]          o_slot_active,
    output logic [NUM_SLOTS*XW-1:0]       o_gadgetX,
    output logic [NUM_SLOTS*YW-1:0]       o_gadgetY,
    output logic [NUM_SLOTS*TYPE_W-1:0]   o_gadget_type,
    output logic                          o_gen_drop
`ifdef GADGET_POOL_MISS_CNT_EN
    ,
    output logic [7:0]                    o_miss_cnt
`endif
);
    localparam int PW = $clog2(NUM_SLOTS + 1);
    localparam logic [YW-1:0]     FLOOR  = YW'(FLOOR_Y);
    localparam logic [STEP_W-1:0] S_INIT = STEP_W'(INIT_STEP);
    localparam logic [STEP_W-1:0] S_MAX  = STEP_W'(MAX_STEP);
    localparam logic [STEP_W-1:0] S_ONE  = STEP_W'(1);

    typedef enum logic [1:0] {IDLE, SELECT, MOVE, FRAME_TERM} state_t;

    state_t state, state_nxt;
    logic [PW-1:0]      ptr, ptr_nxt;
    logic [STEP_W-1:0]  cnt, cnt_nxt;

    logic [NUM_SLOTS-1:0] active, dir;
    logic [XW-1:0]        pos_x [NUM_SLOTS];
    logic [YW-1:0]        pos_y [NUM_SLOTS];
    logic [TYPE_W-1:0]    typ   [NUM_SLOTS];
    logic [STEP_W-1:0]    step  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] eat_mask, scan_mask;
    logic                 any_free, found;
    logic [SW-1:0]        alloc, sel, ps;
    logic [YW-1:0]        cur_y, mv_y;
    logic [STEP_W-1:0]    cur_step, mv_step, cnt_left;
    logic [STEP_W:0]      step2;
    logic                 cur_dir, mv_dir, mv_we, mv_clear;

    assign ps       = ptr[SW-1:0];
    assign cur_y    = pos_y[ps];
    assign cur_step = step[ps];
    assign cur_dir  = dir[ps];
    assign cnt_left = cnt - S_ONE;

    // Eating an inactive slot is a no-op, so only live slots enter the mask.
    always_comb begin
        eat_mask = '0;
        if (i_gadget_eaten && (32'(i_eaten_slot) < NUM_SLOTS))
            eat_mask[i_eaten_slot] = active[i_eaten_slot];
    end

    // Slots eaten this cycle are hidden from the scan so a cleared slot never gets an ack.
    assign scan_mask = active & ~eat_mask;

    always_comb begin
        any_free = 1'b0;
        alloc    = '0;
        found    = 1'b0;
        sel      = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!active[i] && !any_free) begin
                any_free = 1'b1;
                alloc    = SW'(i);
            end
            if (scan_mask[i] && !found && (i >= 32'(ptr))) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        ptr_nxt             = ptr;
        cnt_nxt             = cnt;
        mv_we               = 1'b0;
        mv_clear            = 1'b0;
        mv_y                = cur_y;
        mv_dir              = cur_dir;
        mv_step             = cur_step;
        step2               = '0;
        o_gadget_ack        = 1'b0;
        o_move_slot         = '0;
        o_gadget_frame_term = 1'b0;
        case (state)
            IDLE: if (i_cal_frame) begin
                state_nxt = SELECT;
                ptr_nxt   = '0;
            end
            SELECT: if (found) begin
                state_nxt = MOVE;
                ptr_nxt   = PW'(sel);
                cnt_nxt   = step[sel];
            end else begin
                state_nxt = FRAME_TERM;
            end
            MOVE: begin
                o_gadget_ack = 1'b1;
                o_move_slot  = ps;
                if (eat_mask[ps]) begin
                    state_nxt = SELECT;
                    ptr_nxt   = ptr + PW'(1);
                end else if (i_gadget_req) begin
                    mv_we = 1'b1;
                    if (!cur_dir) begin
                        if (cur_y == '0) begin
                            mv_y   = cur_y + YW'(1);
                            mv_dir = 1'b1;
                        end else begin
                            mv_y   = cur_y - YW'(1);
                            mv_dir = (mv_y == '0);
                        end
                    end else begin
                        mv_y = cur_y + YW'(1);
                    end
                    if (cur_dir && (mv_y >= FLOOR)) begin
                        mv_clear  = 1'b1;
                        state_nxt = SELECT;
                        ptr_nxt   = ptr + PW'(1);
                    end else if (cnt_left == '0) begin
                        // Speed update uses the direction after any bounce off Y=0 this handshake.
                        if (!mv_dir) begin
                            if (cur_step != S_ONE) mv_step = cur_step - STEP_W'(2);
                            else                   mv_dir  = 1'b1;
                        end else begin
                            step2   = {1'b0, cur_step} + (STEP_W+1)'(2);
                            mv_step = (step2 > {1'b0, S_MAX}) ? S_MAX : step2[STEP_W-1:0];
                        end
                        cnt_nxt   = '0;
                        state_nxt = SELECT;
                        ptr_nxt   = ptr + PW'(1);
                    end else begin
                        cnt_nxt = cnt_left;
                    end
                end
            end
            FRAME_TERM: begin
                o_gadget_frame_term = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= '0;
            dir        <= '0;
            o_gen_drop <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                typ[i]   <= '0;
                step[i]  <= '0;
            end
        end else begin
            o_gen_drop <= 1'b0;
            if (i_gadget_gen && (i_gadget_type_by_brick != '0)) begin
                if (any_free) begin
                    active[alloc] <= 1'b1;
                    pos_x[alloc]  <= i_gadget_initX;
                    pos_y[alloc]  <= i_gadget_initY;
                    typ[alloc]    <= i_gadget_type_by_brick;
                    step[alloc]   <= S_INIT;
                    dir[alloc]    <= 1'b0;
                end else begin
                    o_gen_drop <= 1'b1;
                end
            end
            if (mv_we) begin
                pos_y[ps] <= mv_y;
                if (mv_clear) begin
                    active[ps] <= 1'b0;
                    typ[ps]    <= '0;
                end else begin
                    dir[ps]  <= mv_dir;
                    step[ps] <= mv_step;
                end
            end
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (eat_mask[i]) begin
                    active[i] <= 1'b0;
                    typ[i]    <= '0;
                end
            end
        end
    end

`ifdef GADGET_POOL_MISS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          o_miss_cnt <= '0;
        else if (mv_clear && o_miss_cnt != 8'hFF) o_miss_cnt <= o_miss_cnt + 8'd1;
    end
`endif

    assign o_slot_active = active;
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign o_gadgetX[g*XW +: XW]             = pos_x[g];
        assign o_gadgetY[g*YW +: YW]             = pos_y[g];
        assign o_gadget_type[g*TYPE_W +: TYPE_W] = typ[g];
    end

endmodule

// File: tb/tb_gadget_pool.sv
// Directed bench for gadget_pool: spawn/drop, per-frame fall speeds, bounce, floor miss, eat-in-move, reset abort.
module tb_gadget_pool;
    localparam int NS = 4;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cal = 1'b0, gen = 1'b0, eaten = 1'b0, req = 1'b0;
    logic [TW-1:0]     gtype = '0;
    logic [XW-1:0]     init_x = '0;
    logic [YW-1:0]     init_y = '0;
    logic [1:0]        eat_slot = '0;
    logic              ack, term, drop;
    logic [1:0]        move_slot;
    logic [NS-1:0]     act;
    logic [NS*XW-1:0]  gx;
    logic [NS*YW-1:0]  gy;
    logic [NS*TW-1:0]  gt;
`ifdef GADGET_POOL_MISS_CNT_EN
    logic [7:0]        miss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int acks;

    gadget_pool dut (
        .clk(clk), .rst_n(rst_n), .i_cal_frame(cal), .i_gadget_gen(gen),
        .i_gadget_type_by_brick(gtype), .i_gadget_initX(init_x), .i_gadget_initY(init_y),
        .i_gadget_eaten(eaten), .i_eaten_slot(eat_slot), .i_gadget_req(req),
        .o_gadget_ack(ack), .o_move_slot(move_slot), .o_gadget_frame_term(term),
        .o_slot_active(act), .o_gadgetX(gx), .o_gadgetY(gy), .o_gadget_type(gt),
        .o_gen_drop(drop)
`ifdef GADGET_POOL_MISS_CNT_EN
        , .o_miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic spawn(input logic [TW-1:0] t, input logic [XW-1:0] x, input logic [YW-1:0] y);
        gen = 1'b1; gtype = t; init_x = x; init_y = y;
        tick();
        gen = 1'b0; gtype = '0;
    endtask

    task automatic eat(input logic [1:0] s);
        eaten = 1'b1; eat_slot = s;
        tick();
        eaten = 1'b0;
    endtask

    // Pulses i_cal_frame, counts ack cycles until frame_term, then checks the pulse is one cycle wide.
    task automatic run_frame(output int n_ack);
        bit done;
        n_ack = 0;
        done  = 1'b0;
        cal = 1'b1;
        tick();
        cal = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (ack) n_ack++;
            if (term) done = 1'b1;
            else tick();
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL frame_timeout observed=no_term required=term");
        end
        tick();
        chk("term_one_cycle", term, 0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ack", ack, 0);
        chk("rst_term", term, 0);
        chk("rst_active", act, 0);
        chk("rst_y", gy, 0);
        rst_n = 1'b1;
        tick();

        // Single gadget through four frames
        spawn(3'd2, 10'd100, 10'd200);
        chk("sp_active", act, 4'b0001);
        chk("sp_x", gx[9:0], 100);
        chk("sp_y", gy[9:0], 200);
        chk("sp_type", gt[2:0], 2);
        req = 1'b1;
        run_frame(acks); chk("f1_acks", acks, 5); chk("f1_y", gy[9:0], 195);
        run_frame(acks); chk("f2_acks", acks, 3); chk("f2_y", gy[9:0], 192);
        run_frame(acks); chk("f3_acks", acks, 1); chk("f3_y", gy[9:0], 191);
        run_frame(acks); chk("f4_acks", acks, 1); chk("f4_y", gy[9:0], 192);
        run_frame(acks); chk("f5_acks", acks, 3); chk("f5_y", gy[9:0], 195);
        chk("x_fixed", gx[9:0], 100);
        eat(2'd0);
        chk("eat0_active", act, 0);
        chk("eat0_type", gt[2:0], 0);

        // Type 0 ignored; fill pool; fifth spawn drops
        spawn(3'd0, 10'd1, 10'd1);
        chk("type0_active", act, 0);
        chk("type0_drop", drop, 0);
        spawn(3'd1, 10'd10, 10'd50); chk("fill0", act, 4'b0001);
        spawn(3'd2, 10'd20, 10'd60); chk("fill1", act, 4'b0011);
        spawn(3'd3, 10'd30, 10'd70); chk("fill2", act, 4'b0111);
        spawn(3'd4, 10'd40, 10'd80); chk("fill3", act, 4'b1111);
        chk("fill_drop_clear", drop, 0);
        chk("fill_types", gt, {3'd4, 3'd3, 3'd2, 3'd1});
        spawn(3'd5, 10'd50, 10'd90);
        chk("full_drop", drop, 1);
        chk("full_active", act, 4'b1111);
        chk("full_types", gt, {3'd4, 3'd3, 3'd2, 3'd1});
        tick();
        chk("drop_pulse", drop, 0);

        // Eat slot 1 while it is stalled in MOVE
        req = 1'b0;
        cal = 1'b1; tick(); cal = 1'b0;
        tick();
        chk("m0_ack", ack, 1);
        chk("m0_slot", move_slot, 0);
        req = 1'b1;
        repeat (5) tick();
        req = 1'b0;
        chk("m0_y", gy[9:0], 45);
        tick();
        chk("m1_ack", ack, 1);
        chk("m1_slot", move_slot, 1);
        tick();
        chk("m1_stall_ack", ack, 1);
        chk("m1_stall_y", gy[19:10], 60);
        eat(2'd1);
        chk("m1_eat_ack", ack, 0);
        chk("m1_eat_active", act, 4'b1101);
        tick();
        chk("m2_ack", ack, 1);
        chk("m2_slot", move_slot, 2);
        req = 1'b1;
        acks = 0;
        for (int c = 0; c < 30; c++) begin
            if (term) acks++;
            tick();
        end
        chk("m_term_count", acks, 1);
        chk("m2_y", gy[29:20], 65);
        chk("m3_y", gy[39:30], 75);
        eat(2'd0); eat(2'd2); eat(2'd3);
        chk("clear_all", act, 0);

        // Bounce then miss at the floor
        spawn(3'd3, 10'd5, 10'd482);
        run_frame(acks); chk("fl1_acks", acks, 5); chk("fl1_y", gy[9:0], 477);
        run_frame(acks); chk("fl2_y", gy[9:0], 474);
        run_frame(acks); chk("fl3_y", gy[9:0], 473);
        run_frame(acks); chk("fl4_y", gy[9:0], 474);
        run_frame(acks); chk("fl5_acks", acks, 3); chk("fl5_y", gy[9:0], 477);
        run_frame(acks);
        chk("fl6_acks", acks, 2);
        chk("fl6_y", gy[9:0], 479);
        chk("fl6_active", act, 0);
        chk("fl6_type", gt[2:0], 0);
`ifdef GADGET_POOL_MISS_CNT_EN
        chk("miss_cnt", miss_cnt, 1);
`endif

        // Reset in the middle of MOVE
        spawn(3'd1, 10'd7, 10'd300);
        req = 1'b0;
        cal = 1'b1; tick(); cal = 1'b0;
        tick();
        chk("pre_rst_ack", ack, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_active", act, 0);
        chk("arst_x", gx, 0);
        chk("arst_y", gy, 0);
        chk("arst_type", gt, 0);
        chk("arst_term", term, 0);
`ifdef GADGET_POOL_MISS_CNT_EN
        chk("arst_miss", miss_cnt, 0);
`endif
        tick(); tick();
        chk("rst_hold_term", term, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_term", term, 0);
        cal = 1'b1; tick(); cal = 1'b0;
        chk("empty_c1_term", term, 0);
        tick();
        chk("empty_c2_term", term, 1);
        tick();
        chk("empty_c3_term", term, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
